// File: rtl/gadget_pkg.sv
// Shared types for the falling power-up gadget block: gadget kinds, slot record, scan FSM states.
package gadget_pkg;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        BIG        = 4'd1,
        SHRINK     = 4'd2,
        GRAB       = 4'd3,
        FASTER     = 4'd4,
        SLOWER     = 4'd5,
        FIRE       = 4'd6,
        BIG_BALL   = 4'd7,
        SMALL_BALL = 4'd8
    } gadget_t;

    localparam int unsigned GADGET_SPRITE_W = 32;

    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] kind;
    } gadget_slot_t;

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } scan_state_t;

endpackage

// File: rtl/gadget_box_hit.sv
// Combinational point-in-box test for one gadget sprite; also returns the offset into the sprite.
module gadget_box_hit #(
    parameter int unsigned SIZE = 32
) (
    input  logic       enable,
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    output logic       hit,
    output logic [9:0] dx,
    output logic [9:0] dy
);

    logic [10:0] x_end;
    logic [10:0] y_end;

    // 11-bit box edges so sprites near the right/bottom edge do not wrap
    assign x_end = {1'b0, bx} + 11'(SIZE);
    assign y_end = {1'b0, by} + 11'(SIZE);

    assign hit = enable && (px >= bx) && ({1'b0, px} < x_end)
                        && (py >= by) && ({1'b0, py} < y_end);
    assign dx  = px - bx;
    assign dy  = py - by;

endmodule

// File: rtl/gadget_drop.sv
// Falling gadget manager: spawn, per-frame fall/catch/loss scan, sprite ROM pixel path.
// Optional macro GADGET_BLINK_EN blinks gadgets near the bottom of the screen before loss.
module gadget_drop
    import gadget_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned SPRITE_W   = GADGET_SPRITE_W,
    parameter int unsigned FALL_SPEED = 2,
    parameter int unsigned SCREEN_H   = 480
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        spawn_valid,
    output logic        spawn_ready,
    input  logic [9:0]  spawn_x,
    input  logic [9:0]  spawn_y,
    input  logic [3:0]  spawn_type,
    input  logic [9:0]  plat_x,
    input  logic [9:0]  plat_y,
    input  logic [9:0]  plat_w,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [18:0] rom_addr,
    output logic [3:0]  rom_type,
    input  logic [3:0]  rom_data,
    output logic        pixel_valid,
    output logic [3:0]  pixel_color,
    output logic        catch_valid,
    output logic [3:0]  catch_type
);

    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    gadget_slot_t      slots_q [NUM_SLOTS];
    gadget_slot_t      slots_d [NUM_SLOTS];
    scan_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pending_q, pending_d;
    logic              catch_valid_q, catch_valid_d;
    logic [3:0]        catch_type_q, catch_type_d;
    logic              pixel_valid_q;
    logic [3:0]        pixel_color_q;

    logic              any_free;
    logic [IDX_W-1:0]  free_idx;
    gadget_slot_t      cur;
    logic [10:0]       ny;
    logic              caught;

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slots_q[i].active) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign spawn_ready = (state_q == StIdle) && any_free && !frame_tick;

    assign cur    = slots_q[idx_q];
    assign ny     = {1'b0, cur.y} + 11'(FALL_SPEED);
    assign caught = (ny + 11'(SPRITE_W) >= {1'b0, plat_y}) && (ny <= {1'b0, plat_y})
                    && ({1'b0, cur.x} + 11'(SPRITE_W) > {1'b0, plat_x})
                    && ({1'b0, cur.x} < {1'b0, plat_x} + {1'b0, plat_w});

    always_comb begin
        slots_d       = slots_q;
        state_d       = state_q;
        idx_d         = idx_q;
        pending_d     = pending_q;
        catch_valid_d = 1'b0;
        catch_type_d  = 4'd0;
        unique case (state_q)
            StIdle: begin
                // type 0 handshakes normally but never occupies a slot
                if (spawn_valid && spawn_ready && (spawn_type != 4'd0)) begin
                    slots_d[free_idx] = '{active: 1'b1, x: spawn_x, y: spawn_y,
                                          kind: spawn_type};
                end
                if (frame_tick || pending_q) begin
                    state_d   = StScan;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            StScan: begin
                if (frame_tick) begin
                    pending_d = 1'b1;
                end
                if (cur.active) begin
                    if (caught) begin
                        slots_d[idx_q].active = 1'b0;
                        catch_valid_d         = 1'b1;
                        catch_type_d          = cur.kind;
                    end else if (ny >= 11'(SCREEN_H)) begin
                        slots_d[idx_q].active = 1'b0;
                    end else begin
                        slots_d[idx_q].y = ny[9:0];
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pixel path
    logic [NUM_SLOTS-1:0] draw_en;
    logic [NUM_SLOTS-1:0] hit;
    logic [9:0]           hit_dx [NUM_SLOTS];
    logic [9:0]           hit_dy [NUM_SLOTS];
    logic                 any_hit;

`ifdef GADGET_BLINK_EN
    logic [3:0] frame_cnt_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt_q <= 4'd0;
        end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 4'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            draw_en[i] = slots_q[i].active
                         && !(frame_cnt_q[3] && (slots_q[i].y >= 10'(SCREEN_H - 80)));
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            draw_en[i] = slots_q[i].active;
        end
    end
`endif

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
        gadget_box_hit #(
            .SIZE(SPRITE_W)
        ) u_box_hit (
            .enable(draw_en[g]),
            .px    (DrawX),
            .py    (DrawY),
            .bx    (slots_q[g].x),
            .by    (slots_q[g].y),
            .hit   (hit[g]),
            .dx    (hit_dx[g]),
            .dy    (hit_dy[g])
        );
    end

    // Walk downwards so the lowest-index hit is the one left standing
    always_comb begin
        any_hit  = 1'b0;
        rom_type = 4'd0;
        rom_addr = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit  = 1'b1;
                rom_type = slots_q[i].kind;
                rom_addr = 19'(hit_dy[i]) * 19'(SPRITE_W) + 19'(hit_dx[i]);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slots_q       <= '{default: '0};
            state_q       <= StIdle;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            catch_valid_q <= 1'b0;
            catch_type_q  <= 4'd0;
            pixel_valid_q <= 1'b0;
            pixel_color_q <= 4'd0;
        end else begin
            slots_q       <= slots_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            catch_valid_q <= catch_valid_d;
            catch_type_q  <= catch_type_d;
            pixel_valid_q <= any_hit && (rom_data != 4'd0);
            pixel_color_q <= any_hit ? rom_data : 4'd0;
        end
    end

    assign catch_valid = catch_valid_q;
    assign catch_type  = catch_type_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_color = pixel_color_q;

endmodule

// File: tb/tb_gadget_drop.sv
// Self-checking bench for gadget_drop: directed scenarios plus random spawns/frames/probes vs a model.
module tb_gadget_drop;

    localparam int NS = 4;
    localparam int SW = 32;
    localparam int FS = 2;
    localparam int SH = 480;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        spawn_valid = 1'b0;
    logic        spawn_ready;
    logic [9:0]  spawn_x = '0;
    logic [9:0]  spawn_y = '0;
    logic [3:0]  spawn_type = '0;
    logic [9:0]  plat_x = '0;
    logic [9:0]  plat_y = '0;
    logic [9:0]  plat_w = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [18:0] rom_addr;
    logic [3:0]  rom_type;
    logic [3:0]  rom_data = '0;
    logic        pixel_valid;
    logic [3:0]  pixel_color;
    logic        catch_valid;
    logic [3:0]  catch_type;

    gadget_drop #(
        .NUM_SLOTS (NS),
        .SPRITE_W  (SW),
        .FALL_SPEED(FS),
        .SCREEN_H  (SH)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .spawn_valid(spawn_valid),
        .spawn_ready(spawn_ready),
        .spawn_x    (spawn_x),
        .spawn_y    (spawn_y),
        .spawn_type (spawn_type),
        .plat_x     (plat_x),
        .plat_y     (plat_y),
        .plat_w     (plat_w),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .rom_addr   (rom_addr),
        .rom_type   (rom_type),
        .rom_data   (rom_data),
        .pixel_valid(pixel_valid),
        .pixel_color(pixel_color),
        .catch_valid(catch_valid),
        .catch_type (catch_type)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: slot contents and platform
    bit m_act [NS];
    int m_x [NS];
    int m_y [NS];
    int m_kind [NS];
    int p_x, p_y, p_w;
    int exp_off[$], exp_kind[$], got_off[$], got_kind[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NS; i++) m_act[i] = 1'b0;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < NS; i++) if (!m_act[i]) return i;
        return -1;
    endfunction

    // One frame: each active slot falls, then is caught, lost, or kept.
    function automatic void model_frame(input int base);
        int ny;
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                ny = m_y[i] + FS;
                if (ny + SW >= p_y && ny <= p_y && m_x[i] + SW > p_x && m_x[i] < p_x + p_w) begin
                    m_act[i] = 1'b0;
                    exp_off.push_back(base + i);
                    exp_kind.push_back(m_kind[i]);
                end else if (ny >= SH) begin
                    m_act[i] = 1'b0;
                end else begin
                    m_y[i] = ny;
                end
            end
        end
    endfunction

    task automatic set_plat(input int x, input int y, input int w);
        p_x = x; p_y = y; p_w = w;
        plat_x = 10'(x); plat_y = 10'(y); plat_w = 10'(w);
    endtask

    task automatic check_reset_vals();
        check("rst_spawn_ready", spawn_ready, 1);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pixel_color", pixel_color, 0);
        check("rst_catch_valid", catch_valid, 0);
        check("rst_catch_type", catch_type, 0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_clear();
        #1;
        check_reset_vals();
        @(posedge Clk); #1;
        Reset_n = 1'b1;
    endtask

    task automatic spawn(input int x, input int y, input int k);
        int f;
        f = model_free();
        spawn_valid = 1'b1;
        spawn_x = 10'(x); spawn_y = 10'(y); spawn_type = 4'(k);
        #1;
        check("spawn_ready", spawn_ready, (f >= 0) ? 1 : 0);
        @(posedge Clk); #1;
        spawn_valid = 1'b0;
        if (f >= 0 && k != 0) begin
            m_act[f] = 1'b1; m_x[f] = x; m_y[f] = y; m_kind[f] = k;
        end
    endtask

    // rd < 0 picks a random palette index
    task automatic probe(input int x, input int y, input int rd);
        int win, d;
        win = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            if (m_act[i] && x >= m_x[i] && x < m_x[i] + SW && y >= m_y[i] && y < m_y[i] + SW)
                win = i;
        end
        d = (rd < 0) ? int'($urandom_range(0, 15)) : rd;
        DrawX = 10'(x); DrawY = 10'(y); rom_data = 4'(d);
        #1;
        check("rom_type", rom_type, (win >= 0) ? m_kind[win] : 0);
        check("rom_addr", rom_addr, (win >= 0) ? (y - m_y[win]) * SW + (x - m_x[win]) : 0);
        @(posedge Clk); #1;
        check("pixel_valid", pixel_valid, (win >= 0 && d != 0) ? 1 : 0);
        check("pixel_color", pixel_color, (win >= 0) ? d : 0);
    endtask

    // Issue a frame tick; extra adds a second tick mid-scan which must cause one rescan.
    task automatic frame(input bit extra);
        int last, gap_ready;
        exp_off.delete(); exp_kind.delete(); got_off.delete(); got_kind.delete();
        model_frame(2);
        gap_ready = (model_free() >= 0) ? 1 : 0;
        if (extra) model_frame(NS + 3);
        last = extra ? 2 * NS + 3 : NS + 2;
        frame_tick = 1'b1;
        #1;
        check("ready_on_tick", spawn_ready, 0);
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        check("ready_in_scan", spawn_ready, 0);
        for (int c = 2; c <= last; c++) begin
            @(posedge Clk); #1;
            if (catch_valid) begin
                got_off.push_back(c);
                got_kind.push_back(int'(catch_type));
            end
            if (extra && c == NS + 1) check("ready_gap_idle", spawn_ready, gap_ready);
            if (extra && c == NS + 2) check("ready_rescan", spawn_ready, 0);
            if (extra) frame_tick = (c == 2);
        end
        frame_tick = 1'b0;
        check("catch_count", got_off.size(), exp_off.size());
        for (int i = 0; i < exp_off.size() && i < got_off.size(); i++) begin
            check("catch_cycle", got_off[i], exp_off[i]);
            check("catch_type", got_kind[i], exp_kind[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, s, x, y;
        set_plat(0, 0, 0);
        repeat (2) @(posedge Clk);
        #1;
        do_reset();

        // Spawn, fall three frames
        spawn(100, 50, 4);
        check("ready_after_spawn", spawn_ready, 1);
        repeat (3) frame(1'b0);
        probe(100, 56, 5);
        probe(100, 55, 5);

        // Fill all slots, refused fifth spawn, fall to loss without catches
        spawn(300, 446, 2);
        spawn(400, 10, 1);
        spawn(500, 20, 3);
        check("ready_full", spawn_ready, 0);
        spawn(600, 100, 5);
        probe(600, 100, 7);
        frame(1'b0);
        probe(300, 448, 3);
        repeat (15) frame(1'b0);
        probe(331, 509, 2);
        frame(1'b0);
        probe(300, 478, 6);
        spawn(600, 100, 5);
        probe(601, 101, 4);

        // Pending rescan from a tick that lands mid-scan
        frame(1'b1);
        probe(600, 106, 8);

        // Single catch
        do_reset();
        set_plat(90, 100, 64);
        spawn(100, 66, 7);
        frame(1'b0);
        probe(100, 68, 3);

        // Two catches in one scan
        spawn(100, 67, 7);
        spawn(120, 67, 6);
        frame(1'b0);

        // Pixel path and dropped type-0 spawn
        do_reset();
        set_plat(0, 0, 0);
        spawn(10, 10, 0);
        spawn(200, 200, 3);
        probe(10, 10, 9);
        probe(205, 203, 9);
        probe(205, 203, 0);
        spawn(210, 205, 8);
        probe(215, 210, 11);
        probe(240, 234, 12);

        // Reset during a scan discards the pending catch
        set_plat(90, 100, 64);
        spawn(100, 66, 7);
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        Reset_n = 1'b0;
        model_clear();
        #1;
        check_reset_vals();
        repeat (3) begin
            @(posedge Clk); #1;
            check("catch_in_reset", catch_valid, 0);
        end
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        check("catch_after_reset", catch_valid, 0);
        probe(100, 66, 5);

        // Random traffic
        do_reset();
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            s = $urandom_range(0, NS - 1);
            if (r < 4) begin
                spawn($urandom_range(0, 700), $urandom_range(0, 470), $urandom_range(0, 8));
            end else if (r < 7) begin
                if (m_act[s]) begin
                    x = m_x[s] - int'($urandom_range(0, 40));
                    set_plat((x < 0) ? 0 : x, m_y[s] + $urandom_range(0, 40),
                             $urandom_range(0, 100));
                end else begin
                    set_plat($urandom_range(0, 600), $urandom_range(0, 479),
                             $urandom_range(0, 100));
                end
                frame(r == 6);
            end else begin
                x = m_act[s] ? m_x[s] + int'($urandom_range(0, 35)) - 2 : $urandom_range(0, 700);
                y = m_act[s] ? m_y[s] + int'($urandom_range(0, 35)) - 2 : $urandom_range(0, 500);
                probe((x < 0) ? 0 : x, (y < 0) ? 0 : y, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gadget_drop.md
Name: gadget_drop

Overview:
- Manages up to NUM_SLOTS falling power-up gadgets: spawned when a brick breaks, moved down once per frame, caught by the platform or lost off-screen.
- Sits directly upstream of the gadget sprite ROM.
- For the current VGA pixel it drives the ROM address and gadget type, registers the returned palette index, and feeds the colour mapper.
- Reports catches to the game controller.

Parameters:
- NUM_SLOTS, 4: number of concurrent gadgets (1..8).
- SPRITE_W, 32: sprite edge in pixels; ROM depth is SPRITE_W*SPRITE_W (1024).
- FALL_SPEED, 2: pixels moved down per frame tick.
- SCREEN_H, 480: visible lines; y >= SCREEN_H is lost.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-Clk pulse per frame, already synchronous to Clk
- spawn_valid  in  1  spawn request
- spawn_ready  out  1  spawn accepted when valid&ready
- spawn_x, spawn_y  in  10 each  top-left spawn position
- spawn_type  in  4  gadget type 1..8
- plat_x, plat_y  in  10 each  platform top-left
- plat_w  in  10  platform width
- DrawX, DrawY  in  10 each  current pixel
- rom_addr  out  19  read address to sprite ROM
- rom_type  out  4  type select to ROM (0 = none)
- rom_data  in  4  palette index from ROM (combinational)
- pixel_valid  out  1  gadget pixel present and opaque
- pixel_color  out  4  palette index
- catch_valid  out  1  one-cycle pulse per caught gadget
- catch_type  out  4  type of caught gadget

Behaviour:
- Reset: all slots inactive; FSM = IDLE; spawn_ready = 1; pixel_valid = 0; pixel_color = 0; catch_valid = 0; catch_type = 0; pending = 0.
- Slot state: active bit, x[9:0], y[9:0], type[3:0].
- Spawn:
  - spawn_ready = (FSM == IDLE) && any slot inactive && !frame_tick.
  - On handshake, the lowest-index free slot is loaded in the same cycle and is active from the next cycle.
  - spawn_type == 0 is accepted and dropped (no slot used).
- FSM states IDLE, SCAN:
  - IDLE -> SCAN on frame_tick or pending; idx = 0; pending cleared.
  - SCAN processes one slot per cycle; SCAN -> IDLE after idx == NUM_SLOTS-1. Scan length is exactly NUM_SLOTS cycles.
  - frame_tick arriving during SCAN sets pending, so IDLE is re-entered for exactly 1 cycle before rescanning. Further ticks while pending are merged.
- Per-slot SCAN step (inactive slots skipped, no output):
  - ny = y + FALL_SPEED, computed 11-bit with no wrap.
  - Catch if ny+SPRITE_W >= plat_y && ny <= plat_y && x+SPRITE_W > plat_x && x < plat_x+plat_w (all 11-bit). On catch: slot deactivated; catch_valid = 1 and catch_type = type on the next cycle, for one cycle.
  - Else if ny >= SCREEN_H: slot deactivated silently.
  - Else y <= ny.
  - Catch has priority over loss. Multiple catches in one scan pulse on successive cycles.
- Pixel path:
  - Hit for slot i = active && DrawX in [x, x+SPRITE_W) && DrawY in [y, y+SPRITE_W). The lowest-index hit wins.
  - rom_type = winner type, else 0. rom_addr = (DrawY-y)*SPRITE_W + (DrawX-x), zero-extended to 19 bits; rom_addr = 0 when no hit. Both are combinational.
  - Registered, 1-cycle latency: pixel_valid <= hit && rom_data != 0; pixel_color <= hit ? rom_data : 0. Index 0 is transparent.
  - Positions update only in SCAN; mid-frame tearing is accepted.
- Reset asserted mid-SCAN returns everything to reset values immediately; no catch is emitted.

Optional Feature:
- Macro GADGET_BLINK_EN.
- When defined:
  - A 4-bit frame counter increments on each frame_tick; reset value 0.
  - Slots with y >= SCREEN_H-80 are excluded from the hit test while counter[3] == 1 (warning blink before loss).
  - Catch logic is unaffected.
- When undefined: no counter is built and all active slots are always drawn.

Decomposition:
- Shared package gadget_pkg:
  - enum gadget_t: NONE=0, BIG=1, SHRINK=2, GRAB=3, FASTER=4, SLOWER=5, FIRE=6, BIG_BALL=7, SMALL_BALL=8.
  - Constant GADGET_SPRITE_W = 32.
  - Struct gadget_slot_t {active, x, y, type}.
- One sub-module, gadget_box_hit: combinational point-in-box test, instantiated NUM_SLOTS times for the pixel path.

Test Plan:
- Reset, then spawn (x=100, y=50, type=4) -> slot 0 active; spawn_ready stays 1; after 3 frame_ticks y = 56.
- Fill all 4 slots -> spawn_ready = 0; 5th spawn_valid is held off until a slot frees.
- Gadget at y=446 with a platform away from it, one tick -> ny = 448 < 480, stays active; next ticks to y = 478 then ny = 480 -> deactivated; catch_valid never asserts.
- Platform at x=90, y=100, w=64; gadget at x=100, y=66, type=7; tick -> catch_valid pulses once with catch_type = 7; slot freed.
- Two gadgets caught on the same tick -> two catch_valid pulses on consecutive cycles, lowest index first.
- Gadget at (200,200); DrawX=205, DrawY=203 -> rom_addr = 101, rom_type = slot type; rom_data = 9 -> next cycle pixel_valid = 1, pixel_color = 9; rom_data = 0 -> pixel_valid = 0.
